// File: rtl/data_ram_pkg.sv
// Shared types and defaults for the data RAM controller and its storage array.
// The optional byte-lane write mask is enabled with DATA_RAM_BYTE_WRITE_EN.
package data_ram_pkg;

  typedef enum logic {CLEAR, READY} state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_DEPTH      = 1024;

  function automatic int num_lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// Plain single-port storage: byte-lane masked write and a registered read-first port.
// DEPTH must be at least 2 so the address has a nonzero width.
module data_ram_array
  import data_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  localparam int LANES     = num_lanes(DATA_WIDTH),
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LANES-1:0]      lane_en,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;

  // Read returns the pre-write word; the controller merges forwarded lanes on top.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we && lane_en[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM controller: post-reset clear sequence, range check, write-first forwarding.
// Define DATA_RAM_BYTE_WRITE_EN to add the byteEnable lane-mask input.
module data_ram_ctrl
  import data_ram_pkg::*;
#(
  parameter int DATA_WIDTH                   = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH                   = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH                        = DEFAULT_DEPTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int LANES                       = num_lanes(DATA_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  writeEnable,
  input  logic                  readEnable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataC,
`ifdef DATA_RAM_BYTE_WRITE_EN
  input  logic [LANES-1:0]      byteEnable,
`endif
  output logic [DATA_WIDTH-1:0] dataRAMOutput,
  output logic                  dataValid,
  output logic                  busy,
  output logic                  addrError
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  state_t                state_reg;
  logic [AW-1:0]         ptr_reg;
  logic                  busy_reg, valid_reg, err_reg, zero_reg;
  logic [DATA_WIDTH-1:0] fwd_data_reg, fwd_mask_reg;

  logic                  in_range, ready, clearing, wr_ok, rd_ok;
  logic [LANES-1:0]      req_lanes;
  logic [DATA_WIDTH-1:0] req_mask, arr_rdata;

`ifdef DATA_RAM_BYTE_WRITE_EN
  assign req_lanes = byteEnable;
`else
  assign req_lanes = '1;
`endif

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
      assign req_mask[gi*8 +: 8] = {8{req_lanes[gi]}};
    end
  endgenerate

  assign in_range = {1'b0, address} < DEPTH_LIMIT;
  assign ready    = (state_reg == READY) && !reset;
  assign clearing = (state_reg == CLEAR) && !reset;
  assign wr_ok    = ready && writeEnable && in_range;
  assign rd_ok    = ready && readEnable && in_range;

  data_ram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk    (clock),
    .we     (clearing || wr_ok),
    .lane_en(clearing ? {LANES{1'b1}} : req_lanes),
    .addr   (clearing ? ptr_reg : address[AW-1:0]),
    .wdata  (clearing ? CLEAR_VALUE : dataC),
    .re     (rd_ok),
    .rdata  (arr_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= CLEAR;
      ptr_reg   <= '0;
      busy_reg  <= 1'b1;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      zero_reg  <= 1'b1;
    end else begin
      valid_reg <= ready && readEnable;
      err_reg   <= ready && (readEnable || writeEnable) && !in_range;
      // Forwarding context is captured only on reads so the output holds between reads.
      if (ready && readEnable) begin
        zero_reg     <= !in_range;
        fwd_data_reg <= dataC;
        fwd_mask_reg <= wr_ok ? req_mask : '0;
      end
      if (state_reg == CLEAR) begin
        ptr_reg <= ptr_reg + 1'b1;
        if (ptr_reg == LAST_PTR) begin
          state_reg <= READY;
          busy_reg  <= 1'b0;
        end
      end
    end
  end

  assign dataRAMOutput = zero_reg ? '0
                       : (arr_rdata & ~fwd_mask_reg) | (fwd_data_reg & fwd_mask_reg);
  assign dataValid     = valid_reg;
  assign busy          = busy_reg;
  assign addrError     = err_reg;

endmodule
